ddr_rd_arbiter: RTL and testbench
=================================

Name: ddr_rd_arbiter

Overview:
- Shares the single DDR read master between two requesters: the weight-buffer loader (WEI) and the feature-map loader (FTM).
- The master command interface is start/addr/nburst/done.
- Each requester posts one transfer: base address plus total burst count. The arbiter splits each transfer into chunks of at most CHUNK_BURSTS and interleaves the chunks between requesters.
- It honours per-requester hold (buffer full) and reports chunk ownership so the downstream write-enable logic can steer data.

Parameters:
- ADDR_WIDTH, 32, DDR byte-address width.
- NB_WIDTH, 18, width of the burst-count fields.
- BYTES_PER_BURST, 128, bytes per burst; power of 2.
- CHUNK_BURSTS, 32, maximum bursts per master command; power of 2, ≤ 2^NB_WIDTH-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- wei_req_valid  in  1  WEI transfer request.
- wei_req_addr  in  ADDR_WIDTH  WEI base byte address.
- wei_req_nburst  in  NB_WIDTH  WEI total bursts.
- wei_req_ready  out  1  WEI context empty; request accepted when valid&ready.
- wei_hold  in  1  WEI buffer full; blocks new WEI chunks.
- wei_done  out  1  one-cycle pulse when the WEI transfer completes.
- ftm_req_valid, ftm_req_addr, ftm_req_nburst, ftm_req_ready, ftm_hold, ftm_done: same as the WEI ports, for FTM.
- rd_start  out  1  master command start, level-held.
- rd_addr  out  ADDR_WIDTH  chunk address.
- rd_nburst  out  NB_WIDTH  chunk burst count.
- rd_done  in  1  master finished the current command.
- rd_owner  out  1  0 = WEI, 1 = FTM; owner of the in-flight or last command.
- busy  out  1  either context non-empty, or a command is in flight.

Behaviour:
- Reset state and outputs:
  - Async reset clears both contexts, the round-robin pointer (next = WEI) and the FSM (IDLE).
  - All outputs are 0 except wei_req_ready = ftm_req_ready = 1.
  - Asserting reset mid-command abandons the command; the master shares rstn.
- Context per channel: addr_r, rem_r (bursts remaining), active flag.
  - req_ready = ~active.
  - On valid&ready: addr_r <= addr, rem_r <= nburst, active <= 1.
  - A nburst of 0 issues no command: done pulses the next cycle and active clears with it.
- FSM states IDLE, ISSUE, NEXT:
  - IDLE: eligible = active & rem_r != 0 & ~hold.
    - If both channels are eligible, grant the round-robin pointer's channel; otherwise grant the sole eligible channel.
    - On grant, latch chunk = min(rem_r, CHUNK_BURSTS), rd_owner, and the address; go to ISSUE.
  - ISSUE: rd_start = 1; rd_addr/rd_nburst/rd_owner are stable. On rd_done, go to NEXT.
  - NEXT (one cycle), for the owner channel:
    - addr_r += chunk * BYTES_PER_BURST (shift, modulo 2^ADDR_WIDTH).
    - rem_r -= chunk.
    - Round-robin pointer <= other channel.
    - If rem_r becomes 0: owner done pulses, active clears (ready = 1 from the next cycle). Go to IDLE.
- Latency:
  - Acceptance edge T: rd_start first high in the cycle after edge T+1 (IDLE grant at T+1).
  - rd_done at edge D: next grant no earlier than edge D+2.
- Boundary rules:
  - rd_done outside ISSUE is ignored.
  - hold is sampled only in IDLE; hold rising during ISSUE does not abort the command.
  - A new request on a channel can be accepted in the same cycle that the other channel's chunk completes.
  - rd_nburst never exceeds CHUNK_BURSTS.
  - Address wrap-around at 2^ADDR_WIDTH is silent.

Optional Feature:
- Macro DDR_RD_WEI_PRIORITY_EN.
- Defined: WEI has strict priority in IDLE; the round-robin pointer is unused. FTM is granted only when WEI is not eligible.
- Undefined: round-robin as above.

Decomposition:
- Package ddr_rd_pkg:
  - FSM state enum (IDLE/ISSUE/NEXT).
  - OWNER_WEI = 0, OWNER_FTM = 1.
  - BURST_SHIFT = log2(BYTES_PER_BURST).
- Sub-module ddr_rd_ctx, instantiated twice: per-channel context registers, chunk computation, and done-pulse generation.

Test Plan:
- WEI request addr 0x1000, nburst 70, CHUNK 32 -> three commands in order: (0x1000, 32), (0x2000, 32), (0x3000, 6). wei_done pulses once, the cycle after NEXT of the third command.
- WEI (0x0, 64) and FTM (0x80000, 64) posted together -> owner sequence WEI, FTM, WEI, FTM. Addresses 0x0, 0x80000, 0x1000, 0x81000.
- wei_hold = 1 with both channels active -> only FTM commands issue. Releasing hold lets WEI be granted in the next IDLE.
- FTM nburst = 0 -> no rd_start; ftm_done pulses one cycle after acceptance; ftm_req_ready returns to 1.
- rstn low during ISSUE -> rd_start = 0 immediately, busy = 0, both readys = 1. A fresh request then restarts cleanly.
- With DDR_RD_WEI_PRIORITY_EN, both channels active with 64 bursts each -> WEI, WEI, then FTM, FTM.

Source files
------------

// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR read-master arbiter.
// The optional macro DDR_RD_WEI_PRIORITY_EN is consumed by ddr_rd_arbiter.sv.
package ddr_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        NEXT  = 2'd2
    } rd_state_e;

    localparam logic OWNER_WEI = 1'b0;
    localparam logic OWNER_FTM = 1'b1;

    localparam int BYTES_PER_BURST_DFLT = 128;
    localparam int BURST_SHIFT          = $clog2(BYTES_PER_BURST_DFLT);

endpackage

// File: rtl/ddr_rd_ctx.sv
// Per-requester transfer context: address/remaining-burst registers, chunk
// sizing for the next master command, and the transfer-complete pulse.
module ddr_rd_ctx
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int NB_WIDTH     = 18,
    parameter int CHUNK_BURSTS = 32,
    parameter int SHIFT        = BURST_SHIFT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NB_WIDTH-1:0]   req_nburst_i,
    output logic                  req_ready_o,
    input  logic                  advance_i,
    output logic                  active_o,
    output logic                  pend_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [NB_WIDTH-1:0]   chunk_o,
    output logic                  done_o
);

    localparam logic [NB_WIDTH-1:0] CHUNK_CAP = NB_WIDTH'(CHUNK_BURSTS);

    logic                  active_q, active_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB_WIDTH-1:0]   rem_q, rem_d;
    logic [NB_WIDTH-1:0]   chunk;
    logic [ADDR_WIDTH-1:0] addr_step;
    logic                  accept;

    assign accept    = req_valid_i & ~active_q;
    assign chunk     = (rem_q > CHUNK_CAP) ? CHUNK_CAP : rem_q;
    assign addr_step = ADDR_WIDTH'(chunk) << SHIFT;

    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        if (accept) begin
            active_d = 1'b1;
            addr_d   = req_addr_i;
            rem_d    = req_nburst_i;
            // Empty transfer: nothing to issue, report completion straight away.
            done_d   = (req_nburst_i == '0);
        end else if (advance_i) begin
            addr_d = addr_q + addr_step;
            rem_d  = rem_q - chunk;
            if (rem_q == chunk) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end else if (done_q) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
        end else begin
            active_q <= active_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
        end
    end

    assign req_ready_o = ~active_q;
    assign active_o    = active_q;
    assign pend_o      = active_q & (rem_q != '0);
    assign addr_o      = addr_q;
    assign chunk_o     = chunk;
    assign done_o      = done_q;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Shares one DDR read master between the WEI and FTM loaders, chunking each
// transfer. Define DDR_RD_WEI_PRIORITY_EN for strict WEI priority instead of round-robin.
module ddr_rd_arbiter
    import ddr_rd_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int NB_WIDTH        = 18,
    parameter int BYTES_PER_BURST = BYTES_PER_BURST_DFLT,
    parameter int CHUNK_BURSTS    = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wei_req_valid,
    input  logic [ADDR_WIDTH-1:0] wei_req_addr,
    input  logic [NB_WIDTH-1:0]   wei_req_nburst,
    output logic                  wei_req_ready,
    input  logic                  wei_hold,
    output logic                  wei_done,
    input  logic                  ftm_req_valid,
    input  logic [ADDR_WIDTH-1:0] ftm_req_addr,
    input  logic [NB_WIDTH-1:0]   ftm_req_nburst,
    output logic                  ftm_req_ready,
    input  logic                  ftm_hold,
    output logic                  ftm_done,
    output logic                  rd_start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [NB_WIDTH-1:0]   rd_nburst,
    input  logic                  rd_done,
    output logic                  rd_owner,
    output logic                  busy
);

    localparam int SHIFT = $clog2(BYTES_PER_BURST);

    rd_state_e             state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [NB_WIDTH-1:0]   cmd_nb_q, cmd_nb_d;

    logic [1:0]            req_valid, req_ready, hold, advance;
    logic [1:0]            active, pend, done, eligible;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [NB_WIDTH-1:0]   req_nb    [2];
    logic [ADDR_WIDTH-1:0] ctx_addr  [2];
    logic [NB_WIDTH-1:0]   ctx_chunk [2];
    logic                  pick;

    // Channel index 0 is WEI, 1 is FTM, matching the rd_owner encoding.
    assign req_valid = {ftm_req_valid, wei_req_valid};
    assign hold      = {ftm_hold, wei_hold};
    assign req_addr[OWNER_WEI] = wei_req_addr;
    assign req_addr[OWNER_FTM] = ftm_req_addr;
    assign req_nb[OWNER_WEI]   = wei_req_nburst;
    assign req_nb[OWNER_FTM]   = ftm_req_nburst;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ctx
            assign advance[gi] = (state_q == NEXT) && (owner_q == 1'(gi));

            ddr_rd_ctx #(
                .ADDR_WIDTH   (ADDR_WIDTH),
                .NB_WIDTH     (NB_WIDTH),
                .CHUNK_BURSTS (CHUNK_BURSTS),
                .SHIFT        (SHIFT)
            ) u_ctx (
                .clk          (clk),
                .rstn         (rstn),
                .req_valid_i  (req_valid[gi]),
                .req_addr_i   (req_addr[gi]),
                .req_nburst_i (req_nb[gi]),
                .req_ready_o  (req_ready[gi]),
                .advance_i    (advance[gi]),
                .active_o     (active[gi]),
                .pend_o       (pend[gi]),
                .addr_o       (ctx_addr[gi]),
                .chunk_o      (ctx_chunk[gi]),
                .done_o       (done[gi])
            );
        end
    endgenerate

    assign eligible = pend & ~hold;

`ifdef DDR_RD_WEI_PRIORITY_EN
    always_comb begin
        pick = eligible[OWNER_WEI] ? OWNER_WEI : OWNER_FTM;
    end
`else
    logic rr_q, rr_d;

    always_comb begin
        pick = (&eligible) ? rr_q : (eligible[OWNER_FTM] ? OWNER_FTM : OWNER_WEI);
    end

    always_comb begin
        rr_d = rr_q;
        if (state_q == NEXT) begin
            rr_d = ~owner_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q <= OWNER_WEI;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_addr_d = cmd_addr_q;
        cmd_nb_d   = cmd_nb_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    owner_d    = pick;
                    cmd_addr_d = ctx_addr[pick];
                    cmd_nb_d   = ctx_chunk[pick];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (rd_done) begin
                    state_d = NEXT;
                end
            end
            NEXT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_WEI;
            cmd_addr_q <= '0;
            cmd_nb_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_nb_q   <= cmd_nb_d;
        end
    end

    assign rd_start      = (state_q == ISSUE);
    assign rd_addr       = cmd_addr_q;
    assign rd_nburst     = cmd_nb_q;
    assign rd_owner      = owner_q;
    assign busy          = (|active) | (state_q != IDLE);
    assign wei_req_ready = req_ready[OWNER_WEI];
    assign ftm_req_ready = req_ready[OWNER_FTM];
    assign wei_done      = done[OWNER_WEI];
    assign ftm_done      = done[OWNER_FTM];

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed scoreboard bench for ddr_rd_arbiter with a simple read-master model
// that answers each command with rd_done after a random short latency.
module tb_ddr_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wei_req_valid = 1'b0, ftm_req_valid = 1'b0;
    logic [31:0] wei_req_addr = '0, ftm_req_addr = '0;
    logic [17:0] wei_req_nburst = '0, ftm_req_nburst = '0;
    logic        wei_req_ready, ftm_req_ready;
    logic        wei_hold = 1'b0, ftm_hold = 1'b0;
    logic        wei_done, ftm_done;
    logic        rd_start, rd_done, rd_owner, busy;
    logic [31:0] rd_addr;
    logic [17:0] rd_nburst;

    typedef struct packed {
        logic [31:0] addr;
        logic [17:0] nb;
        logic        owner;
    } cmd_t;

    cmd_t exp_q[$];
    int   total = 0, bad = 0;
    int   cyc = 0;
    int   wei_done_cnt = 0, ftm_done_cnt = 0;
    int   wei_done_cyc = -1, hs_cyc = -1;

    always #5 clk = ~clk;

    ddr_rd_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .wei_req_valid  (wei_req_valid),
        .wei_req_addr   (wei_req_addr),
        .wei_req_nburst (wei_req_nburst),
        .wei_req_ready  (wei_req_ready),
        .wei_hold       (wei_hold),
        .wei_done       (wei_done),
        .ftm_req_valid  (ftm_req_valid),
        .ftm_req_addr   (ftm_req_addr),
        .ftm_req_nburst (ftm_req_nburst),
        .ftm_req_ready  (ftm_req_ready),
        .ftm_hold       (ftm_hold),
        .ftm_done       (ftm_done),
        .rd_start       (rd_start),
        .rd_addr        (rd_addr),
        .rd_nburst      (rd_nburst),
        .rd_done        (rd_done),
        .rd_owner       (rd_owner),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic owner, input logic [31:0] a, input logic [17:0] nb);
        cmd_t c;
        c.addr  = a;
        c.nb    = nb;
        c.owner = owner;
        exp_q.push_back(c);
    endtask

    // Present requests for one clock; caller is positioned away from posedge.
    task automatic drive_req(input bit dw, input logic [31:0] aw, input logic [17:0] nw,
                             input bit df, input logic [31:0] af, input logic [17:0] nf);
        if (dw) begin
            check("wei_ready_before_req", wei_req_ready, 1);
            wei_req_valid = 1'b1; wei_req_addr = aw; wei_req_nburst = nw;
        end
        if (df) begin
            check("ftm_ready_before_req", ftm_req_ready, 1);
            ftm_req_valid = 1'b1; ftm_req_addr = af; ftm_req_nburst = nf;
        end
        $display("req: wei=%0b (%0h,%0d) ftm=%0b (%0h,%0d)", dw, aw, nw, df, af, nf);
        @(posedge clk);
        #1;
        wei_req_valid = 1'b0;
        ftm_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit ch, input int target);
        int n = 0;
        while (((ch ? ftm_done_cnt : wei_done_cnt) < target) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        check(tag, (n < 400), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk); #1; n++;
        end
        check(tag, (n < 400), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Read-master model: answers an issued command after 0..3 extra cycles.
    initial begin
        int cnt = 0;
        int lat = 1;
        rd_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                rd_done = 1'b0;
                cnt = 0;
            end else if (rd_done) begin
                rd_done = 1'b0;
            end else if (rd_start) begin
                if (cnt >= lat) begin
                    rd_done = 1'b1;
                    cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Command monitor: compare each new rd_start against the scoreboard.
    initial begin
        bit   prev_start = 1'b0;
        cmd_t e;
        forever begin
            @(negedge clk);
            if (rd_start && !prev_start) begin
                $display("cmd: owner=%0d addr=%0h nburst=%0d", rd_owner, rd_addr, rd_nburst);
                if (exp_q.size() == 0) begin
                    check("cmd_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", rd_addr, e.addr);
                    check("cmd_nburst", rd_nburst, e.nb);
                    check("cmd_owner", rd_owner, e.owner);
                    check("nburst_le_chunk", (rd_nburst <= 18'd32), 1);
                end
            end
            if (rd_start && rd_done) hs_cyc = cyc;
            if (wei_done) begin
                wei_done_cnt++;
                wei_done_cyc = cyc;
            end
            if (ftm_done) ftm_done_cnt++;
            prev_start = rd_start;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_rd_start", rd_start, 0);
        check("rst_busy", busy, 0);
        check("rst_wei_ready", wei_req_ready, 1);
        check("rst_ftm_ready", ftm_req_ready, 1);
        check("rst_wei_done", wei_done, 0);
        check("rst_ftm_done", ftm_done, 0);
        check("rst_rd_owner", rd_owner, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_nburst", rd_nburst, 0);
        rstn = 1'b1;
        @(negedge clk); #1;

        // Both channels posted together
`ifdef DDR_RD_WEI_PRIORITY_EN
        push(1'b0, 32'h0000_0000, 18'd32);
        push(1'b0, 32'h0000_1000, 18'd32);
        push(1'b1, 32'h0008_0000, 18'd32);
        push(1'b1, 32'h0008_1000, 18'd32);
`else
        push(1'b0, 32'h0000_0000, 18'd32);
        push(1'b1, 32'h0008_0000, 18'd32);
        push(1'b0, 32'h0000_1000, 18'd32);
        push(1'b1, 32'h0008_1000, 18'd32);
`endif
        drive_req(1'b1, 32'h0, 18'd64, 1'b1, 32'h0008_0000, 18'd64);
        wait_done("both_ftm_done_timeout", 1'b1, 1);
        wait_idle("both_idle_timeout");
        check("both_wei_done_cnt", wei_done_cnt, 1);
        check("both_ftm_done_cnt", ftm_done_cnt, 1);

        // Single WEI transfer split into three chunks
        base = wei_done_cnt;
        push(1'b0, 32'h0000_1000, 18'd32);
        push(1'b0, 32'h0000_2000, 18'd32);
        push(1'b0, 32'h0000_3000, 18'd6);
        drive_req(1'b1, 32'h0000_1000, 18'd70, 1'b0, 32'h0, 18'd0);
        wait_done("split_done_timeout", 1'b0, base + 1);
        check("split_done_timing", wei_done_cyc - hs_cyc, 2);
        wait_idle("split_idle_timeout");
        repeat (5) @(negedge clk);
        #1;
        check("split_done_once", wei_done_cnt, base + 1);
        check("split_ready_back", wei_req_ready, 1);

        // Zero-length FTM transfer
        base = ftm_done_cnt;
        drive_req(1'b0, 32'h0, 18'd0, 1'b1, 32'h0000_5000, 18'd0);
        @(negedge clk); #1;
        check("zero_done_pulse", ftm_done, 1);
        check("zero_no_start", rd_start, 0);
        @(negedge clk); #1;
        check("zero_done_low", ftm_done, 0);
        check("zero_ready_back", ftm_req_ready, 1);
        repeat (3) @(negedge clk);
        #1;
        check("zero_no_start_later", rd_start, 0);
        check("zero_idle", busy, 0);
        check("zero_done_cnt", ftm_done_cnt, base + 1);

        // WEI held: only FTM issues until hold is released
        base = ftm_done_cnt;
        wei_hold = 1'b1;
        push(1'b1, 32'h0009_0000, 18'd32);
        push(1'b1, 32'h0009_1000, 18'd8);
        drive_req(1'b1, 32'h0001_0000, 18'd64, 1'b1, 32'h0009_0000, 18'd40);
        wait_done("hold_ftm_timeout", 1'b1, base + 1);
        check("hold_no_wei_cmd", rd_start, 0);
        check("hold_wei_pending", wei_req_ready, 0);
        push(1'b0, 32'h0001_0000, 18'd32);
        push(1'b0, 32'h0001_1000, 18'd32);
        wei_hold = 1'b0;
        @(negedge clk); #1;
        check("hold_release_start", rd_start, 1);
        check("hold_release_owner", rd_owner, 0);
        wait_idle("hold_idle_timeout");

        // Reset asserted while a command is in ISSUE
        push(1'b0, 32'h0000_4000, 18'd32);
        drive_req(1'b1, 32'h0000_4000, 18'd64, 1'b0, 32'h0, 18'd0);
        n = 0;
        while (!rd_start && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("rst_mid_reach_issue", rd_start, 1);
        rstn = 1'b0;
        #1;
        check("rst_mid_start", rd_start, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wei_ready", wei_req_ready, 1);
        check("rst_mid_ftm_ready", ftm_req_ready, 1);
        check("rst_mid_nburst", rd_nburst, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_mid_queue", exp_q.size(), 0);
        rstn = 1'b1;
        @(negedge clk); #1;
        base = ftm_done_cnt;
        push(1'b1, 32'h0000_8000, 18'd5);
        drive_req(1'b0, 32'h0, 18'd0, 1'b1, 32'h0000_8000, 18'd5);
        wait_done("restart_done_timeout", 1'b1, base + 1);
        wait_idle("restart_idle_timeout");
        check("restart_owner", rd_owner, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
